// File: rtl/rob_mc.sv
// rob_mc: reorder buffer with WB_N broadcast writeback channels and up to COMMIT_W
// in-order retires per cycle; a mispredicted branch/JALR at retire flushes every entry.
module rob_mc #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned TAG_W    = 4,
  parameter int unsigned WB_N     = 2,
  parameter int unsigned COMMIT_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rdy,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  output logic [TAG_W-1:0]      issue_tag,
  input  logic [1:0]            issue_kind,
  input  logic [4:0]            issue_rd,
  input  logic [31:0]           issue_pc,
  input  logic                  issue_pred_jump,
  input  logic                  issue_done,
  input  logic [WB_N-1:0]       wb_valid,
  input  logic [WB_N*TAG_W-1:0] wb_tag,
  input  logic [WB_N*32-1:0]    wb_val,
  input  logic [WB_N-1:0]       wb_jump,
  input  logic [WB_N*32-1:0]    wb_target,
  input  logic [TAG_W-1:0]      q1_tag,
  input  logic [TAG_W-1:0]      q2_tag,
  output logic                  q1_ready,
  output logic                  q2_ready,
  output logic [31:0]           q1_val,
  output logic [31:0]           q2_val,
  output logic [1:0]            cm_reg_en,
  output logic [9:0]            cm_rd,
  output logic [63:0]           cm_val,
  output logic [2*TAG_W-1:0]    cm_tag,
  output logic                  cm_store,
  output logic                  cm_br_en,
  output logic                  cm_br_jump,
  output logic [31:0]           cm_br_pc,
  output logic                  flush,
  output logic [31:0]           flush_pc
);

  typedef enum logic [1:0] {
    KindReg    = 2'd0,
    KindStore  = 2'd1,
    KindBranch = 2'd2,
    KindJalr   = 2'd3
  } kind_e;

  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d, head_p1;
  logic [TAG_W:0]   count_q, count_d;
  logic [DEPTH-1:0] ready_q, ready_d;
  kind_e            kind_q   [DEPTH];
  logic [4:0]       rd_q     [DEPTH];
  logic [31:0]      pc_q     [DEPTH];
  logic [31:0]      val_q    [DEPTH];
  logic [31:0]      target_q [DEPTH];
  logic [DEPTH-1:0] pred_q;
  logic [DEPTH-1:0] jump_q;
  logic             flush_q;
  logic [31:0]      flush_pc_q;

  logic             alloc, ret0, ret1, mispredict;
  logic [1:0]       n_ret;
  logic [WB_N-1:0]  wb_we;
  logic [TAG_W-1:0] wb_tag_a [WB_N];
  logic [31:0]      wb_val_a [WB_N];
  logic [31:0]      wb_tgt_a [WB_N];

  logic [1:0]         reg_en_d;
  logic [9:0]         rd_d;
  logic [63:0]        val_d;
  logic [2*TAG_W-1:0] tag_d;
  logic               store_d, br_en_d, br_jump_d;
  logic [31:0]        br_pc_d;

  for (genvar g = 0; g < WB_N; g++) begin : g_wb
    assign wb_tag_a[g] = wb_tag[g*TAG_W +: TAG_W];
    assign wb_val_a[g] = wb_val[g*32 +: 32];
    assign wb_tgt_a[g] = wb_target[g*32 +: 32];
  end

  assign head_p1     = head_q + TAG_W'(1);
  assign issue_ready = (count_q < (TAG_W+1)'(DEPTH)) && !flush_q;
  assign issue_tag   = tail_q;
  assign alloc       = rdy && issue_valid && issue_ready;
  assign flush       = flush_q;
  assign flush_pc    = flush_pc_q;

  // Retire decision uses pre-edge state only; slot1 must be a plain register write
  // so that a store or control op never shares a group with another of its kind.
  always_comb begin
    ret0 = (count_q != '0) && ready_q[head_q];
    ret1 = (COMMIT_W > 1) && ret0 && (count_q > (TAG_W+1)'(1)) && ready_q[head_p1] &&
           (kind_q[head_p1] == KindReg) &&
           ((kind_q[head_q] == KindReg) || (kind_q[head_q] == KindStore));
    mispredict = ret0 && ((kind_q[head_q] == KindBranch) || (kind_q[head_q] == KindJalr)) &&
                 (pred_q[head_q] != jump_q[head_q]);
    n_ret = {1'b0, ret0} + {1'b0, ret1};
  end

  always_comb begin
    for (int i = 0; i < WB_N; i++) begin
      wb_we[i] = rdy && wb_valid[i] && !flush_q && !(alloc && (wb_tag_a[i] == tail_q));
    end
  end

  always_comb begin
    ready_d = ready_q;
    for (int i = 0; i < WB_N; i++) begin
      if (wb_we[i]) ready_d[wb_tag_a[i]] = 1'b1;
    end
    if (ret0)  ready_d[head_q]  = 1'b0;
    if (ret1)  ready_d[head_p1] = 1'b0;
    if (alloc) ready_d[tail_q]  = issue_done;
    head_d  = head_q + TAG_W'(n_ret);
    tail_d  = tail_q + TAG_W'(alloc);
    count_d = count_q + (TAG_W+1)'(alloc) - (TAG_W+1)'(n_ret);
    if (mispredict) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      ready_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ready_q <= '0;
    end else if (rdy) begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ready_q <= ready_d;
    end
  end

  // Payload needs no reset: a slot is only read once allocation has rewritten it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WB_N; i++) begin
      if (wb_we[i]) begin
        val_q[wb_tag_a[i]]    <= wb_val_a[i];
        jump_q[wb_tag_a[i]]   <= wb_jump[i];
        target_q[wb_tag_a[i]] <= wb_tgt_a[i];
      end
    end
    if (alloc) begin
      kind_q[tail_q]   <= kind_e'(issue_kind);
      rd_q[tail_q]     <= issue_rd;
      pc_q[tail_q]     <= issue_pc;
      pred_q[tail_q]   <= issue_pred_jump;
      val_q[tail_q]    <= '0;
      jump_q[tail_q]   <= 1'b0;
      target_q[tail_q] <= '0;
    end
  end

  // Highest-index writeback channel wins over the stored entry.
  always_comb begin
    q1_ready = ready_q[q1_tag];
    q1_val   = val_q[q1_tag];
    q2_ready = ready_q[q2_tag];
    q2_val   = val_q[q2_tag];
    for (int i = 0; i < WB_N; i++) begin
      if (wb_valid[i] && (wb_tag_a[i] == q1_tag)) begin
        q1_ready = 1'b1;
        q1_val   = wb_val_a[i];
      end
      if (wb_valid[i] && (wb_tag_a[i] == q2_tag)) begin
        q2_ready = 1'b1;
        q2_val   = wb_val_a[i];
      end
    end
  end

  always_comb begin
    reg_en_d  = '0;
    rd_d      = '0;
    val_d     = '0;
    tag_d     = '0;
    store_d   = 1'b0;
    br_en_d   = 1'b0;
    br_jump_d = 1'b0;
    br_pc_d   = '0;
    if (ret0) begin
      tag_d[0 +: TAG_W] = head_q;
      case (kind_q[head_q])
        KindReg, KindJalr: begin
          reg_en_d[0]  = 1'b1;
          rd_d[4:0]    = rd_q[head_q];
          val_d[31:0]  = val_q[head_q];
        end
        KindStore: store_d = 1'b1;
        KindBranch: begin
          br_en_d   = 1'b1;
          br_jump_d = jump_q[head_q];
          br_pc_d   = pc_q[head_q];
        end
        default: ;
      endcase
    end
    if (ret1) begin
      tag_d[TAG_W +: TAG_W] = head_p1;
      reg_en_d[1]  = 1'b1;
      rd_d[9:5]    = rd_q[head_p1];
      val_d[63:32] = val_q[head_p1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cm_reg_en  <= '0;
      cm_rd      <= '0;
      cm_val     <= '0;
      cm_tag     <= '0;
      cm_store   <= 1'b0;
      cm_br_en   <= 1'b0;
      cm_br_jump <= 1'b0;
      cm_br_pc   <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
    end else if (!rdy) begin
      cm_reg_en  <= '0;
      cm_rd      <= '0;
      cm_val     <= '0;
      cm_tag     <= '0;
      cm_store   <= 1'b0;
      cm_br_en   <= 1'b0;
      cm_br_jump <= 1'b0;
      cm_br_pc   <= '0;
      flush_q    <= 1'b0;
    end else begin
      cm_reg_en  <= reg_en_d;
      cm_rd      <= rd_d;
      cm_val     <= val_d;
      cm_tag     <= tag_d;
      cm_store   <= store_d;
      cm_br_en   <= br_en_d;
      cm_br_jump <= br_jump_d;
      cm_br_pc   <= br_pc_d;
      flush_q    <= mispredict;
      if (mispredict) flush_pc_q <= target_q[head_q];
    end
  end

endmodule

// File: tb/tb_rob_mc.sv
// Randomized scoreboard bench for rob_mc: a queue-based in-order model predicts every
// commit group, which a separate monitor matches against the registered commit outputs.
module tb_rob_mc;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned WB_N  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rdy;
  logic issue_valid, issue_ready;
  logic [TAG_W-1:0] issue_tag;
  logic [1:0] issue_kind;
  logic [4:0] issue_rd;
  logic [31:0] issue_pc;
  logic issue_pred_jump, issue_done;
  logic [WB_N-1:0] wb_valid, wb_jump;
  logic [WB_N*TAG_W-1:0] wb_tag;
  logic [WB_N*32-1:0] wb_val, wb_target;
  logic [TAG_W-1:0] q1_tag, q2_tag;
  logic q1_ready, q2_ready;
  logic [31:0] q1_val, q2_val;
  logic [1:0] cm_reg_en;
  logic [9:0] cm_rd;
  logic [63:0] cm_val;
  logic [2*TAG_W-1:0] cm_tag;
  logic cm_store, cm_br_en, cm_br_jump;
  logic [31:0] cm_br_pc;
  logic flush;
  logic [31:0] flush_pc;

  rob_mc #(.DEPTH(DEPTH), .TAG_W(TAG_W), .WB_N(WB_N), .COMMIT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_tag(issue_tag),
    .issue_kind(issue_kind), .issue_rd(issue_rd), .issue_pc(issue_pc),
    .issue_pred_jump(issue_pred_jump), .issue_done(issue_done),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_val(wb_val), .wb_jump(wb_jump),
    .wb_target(wb_target), .q1_tag(q1_tag), .q2_tag(q2_tag),
    .q1_ready(q1_ready), .q2_ready(q2_ready), .q1_val(q1_val), .q2_val(q2_val),
    .cm_reg_en(cm_reg_en), .cm_rd(cm_rd), .cm_val(cm_val), .cm_tag(cm_tag),
    .cm_store(cm_store), .cm_br_en(cm_br_en), .cm_br_jump(cm_br_jump),
    .cm_br_pc(cm_br_pc), .flush(flush), .flush_pc(flush_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             ready;
    logic [1:0]       kind;
    logic [4:0]       rd;
    logic [31:0]      pc;
    logic             pred;
    logic [31:0]      val;
    logic             jump;
    logic [31:0]      target;
    logic [TAG_W-1:0] tag;
  } ent_t;

  typedef struct packed {
    logic [1:0]         reg_en;
    logic [9:0]         rd;
    logic [63:0]        val;
    logic [2*TAG_W-1:0] tag;
    logic               store;
    logic               br_en;
    logic               br_jump;
    logic [31:0]        br_pc;
    logic               flush;
    logic [31:0]        flush_pc;
  } cm_t;

  ent_t mq[$];
  cm_t  sb_q[$];
  int   sb_due[$];
  logic [TAG_W-1:0] m_tail;
  bit   m_flush;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin : monitor
    cm_t act, e;
    int d;
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      act = '{reg_en: cm_reg_en, rd: cm_rd, val: cm_val, tag: cm_tag, store: cm_store,
              br_en: cm_br_en, br_jump: cm_br_jump, br_pc: cm_br_pc, flush: flush,
              flush_pc: flush ? flush_pc : 32'h0};
      if (act.reg_en != 2'b00 || act.store || act.br_en || act.flush) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL commit_unexpected: got %h expected no commit", act);
        end else begin
          e = sb_q.pop_front();
          d = sb_due.pop_front();
          if (act !== e || d != cyc) begin
            n_fail++;
            $display("FAIL commit: got %h expected %h (cycle %0d due %0d)", act, e, cyc, d);
          end
        end
      end else if (sb_q.size() > 0 && sb_due[0] <= cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL commit_missing: got no commit expected %h", sb_q[0]);
        void'(sb_q.pop_front());
        void'(sb_due.pop_front());
      end
    end
  end

  task automatic clear_inputs();
    rdy = 1'b1;
    issue_valid = 1'b0; issue_kind = 2'd0; issue_rd = 5'd0; issue_pc = 32'h0;
    issue_pred_jump = 1'b0; issue_done = 1'b0;
    wb_valid = '0; wb_jump = '0; wb_tag = '0; wb_val = '0; wb_target = '0;
    q1_tag = '0; q2_tag = '0;
  endtask

  task automatic set_issue(input logic [1:0] kind, input logic [4:0] rd, input logic pred,
                           input logic done);
    issue_valid = 1'b1; issue_kind = kind; issue_rd = rd;
    issue_pc = 32'h100 + 32'($urandom_range(0, 255)) * 4;
    issue_pred_jump = pred; issue_done = done;
  endtask

  task automatic set_wb(input int ch, input logic [TAG_W-1:0] tag, input logic [31:0] val,
                        input logic jump, input logic [31:0] target);
    wb_valid[ch] = 1'b1;
    wb_tag[ch*TAG_W +: TAG_W] = tag;
    wb_val[ch*32 +: 32] = val;
    wb_jump[ch] = jump;
    wb_target[ch*32 +: 32] = target;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    #1;
    chk("rst_issue_ready", 64'(issue_ready), 64'(1));
    chk("rst_issue_tag", 64'(issue_tag), 64'(0));
    chk("rst_cm", 64'({cm_reg_en, cm_store, cm_br_en, cm_br_jump, cm_rd, cm_tag}), 64'(0));
    chk("rst_flush", 64'({flush, flush_pc}), 64'(0));
    mq.delete(); sb_q.delete(); sb_due.delete();
    m_tail = '0; m_flush = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [TAG_W-1:0] t, output bit known, output logic r,
                        output logic [31:0] v);
    known = 0; r = 1'b0; v = '0;
    for (int i = 0; i < int'(WB_N); i++) begin
      if (wb_valid[i] && wb_tag[i*TAG_W +: TAG_W] == t) begin
        known = 1; r = 1'b1; v = wb_val[i*32 +: 32];
      end
    end
    if (!known) begin
      foreach (mq[k]) begin
        if (mq[k].tag == t) begin
          known = 1; r = mq[k].ready; v = mq[k].val;
        end
      end
    end
  endtask

  task automatic fill_slot(inout cm_t rec, input int s, input ent_t e);
    rec.tag[s*TAG_W +: TAG_W] = e.tag;
    if (e.kind == 2'd0 || e.kind == 2'd3) begin
      rec.reg_en[s] = 1'b1;
      rec.rd[s*5 +: 5] = e.rd;
      rec.val[s*32 +: 32] = e.val;
    end else if (e.kind == 2'd1) begin
      rec.store = 1'b1;
    end else begin
      rec.br_en = 1'b1; rec.br_jump = e.jump; rec.br_pc = e.pc;
    end
  endtask

  // One cycle: inputs are already driven; check combinational outputs, advance the model.
  task automatic step();
    bit exp_rdy, known, misp, alloc;
    logic r;
    logic [31:0] v;
    cm_t rec;
    int n;
    ent_t ne;
    #1;
    exp_rdy = (mq.size() < int'(DEPTH)) && !m_flush;
    chk("issue_ready", 64'(issue_ready), 64'(exp_rdy));
    chk("issue_tag", 64'(issue_tag), 64'(m_tail));
    lookup(q1_tag, known, r, v);
    if (known) begin
      chk("q1_ready", 64'(q1_ready), 64'(r));
      chk("q1_val", 64'(q1_val), 64'(v));
    end
    lookup(q2_tag, known, r, v);
    if (known) begin
      chk("q2_ready", 64'(q2_ready), 64'(r));
      chk("q2_val", 64'(q2_val), 64'(v));
    end
    if (!rdy) begin
      m_flush = 0;
    end else begin
      rec = '0; n = 0; misp = 0;
      alloc = issue_valid && exp_rdy;
      if (mq.size() > 0 && mq[0].ready) begin
        n = 1;
        fill_slot(rec, 0, mq[0]);
        if (mq.size() > 1 && mq[1].ready && mq[1].kind == 2'd0 && mq[0].kind < 2'd2) begin
          n = 2;
          fill_slot(rec, 1, mq[1]);
        end
        misp = mq[0].kind >= 2'd2 && mq[0].pred != mq[0].jump;
        if (misp) begin
          rec.flush = 1'b1; rec.flush_pc = mq[0].target;
        end
      end
      if (!m_flush) begin
        for (int i = 0; i < int'(WB_N); i++) begin
          if (wb_valid[i]) begin
            foreach (mq[k]) begin
              if (mq[k].tag == wb_tag[i*TAG_W +: TAG_W]) begin
                mq[k].ready = 1'b1; mq[k].val = wb_val[i*32 +: 32];
                mq[k].jump = wb_jump[i]; mq[k].target = wb_target[i*32 +: 32];
              end
            end
          end
        end
      end
      repeat (n) void'(mq.pop_front());
      if (alloc) begin
        ne = '{ready: issue_done, kind: issue_kind, rd: issue_rd, pc: issue_pc,
               pred: issue_pred_jump, val: 32'h0, jump: 1'b0, target: 32'h0, tag: m_tail};
        mq.push_back(ne);
        m_tail = m_tail + 1'b1;
      end
      if (misp) begin
        mq.delete();
        m_tail = '0;
      end
      m_flush = misp;
      if (n > 0) begin
        sb_q.push_back(rec);
        sb_due.push_back(cyc + 1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      clear_inputs();
      step();
    end
  endtask

  task automatic random_inputs();
    int r, k;
    clear_inputs();
    rdy = ($urandom_range(0, 15) != 0);
    if ($urandom_range(0, 3) != 0) begin
      r = $urandom_range(0, 19);
      set_issue((r < 12) ? 2'd0 : (r < 15) ? 2'd1 : (r < 18) ? 2'd2 : 2'd3,
                5'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
    end
    for (int i = 0; i < int'(WB_N); i++) begin
      if (mq.size() > 0 && $urandom_range(0, 1) == 0) begin
        k = $urandom_range(0, mq.size() - 1);
        set_wb(i, mq[k].tag, $urandom,
               ($urandom_range(0, 7) == 0) ? ~mq[k].pred : mq[k].pred, $urandom & ~32'h3);
      end
    end
    q1_tag = (mq.size() > 0) ? mq[$urandom_range(0, mq.size() - 1)].tag : TAG_W'($urandom);
    q2_tag = (mq.size() > 0) ? mq[$urandom_range(0, mq.size() - 1)].tag : TAG_W'($urandom);
    if ($urandom_range(0, 3) == 0) q2_tag = wb_tag[TAG_W +: TAG_W];
  endtask

  initial begin
    clear_inputs();
    #2;
    do_reset();

    // Three ready register writes back to back.
    for (int i = 1; i <= 3; i++) begin
      clear_inputs(); set_issue(2'd0, 5'(i), 1'b0, 1'b1); step();
    end
    idle(4);

    // Fill to DEPTH with nothing ready, then release the head.
    for (int i = 0; i < int'(DEPTH); i++) begin
      clear_inputs(); set_issue(2'd0, 5'(i + 1), 1'b0, 1'b0); step();
    end
    clear_inputs(); set_issue(2'd0, 5'd9, 1'b0, 1'b0); step();
    set_wb(0, '0, 32'hA5A5_0000, 1'b0, 32'h0); step();
    wb_valid = '0; step();
    step();
    for (int t = 1; t < int'(DEPTH); t++) begin
      clear_inputs(); set_wb(t % 2, TAG_W'(t), 32'h1000 + 32'(t), 1'b0, 32'h0); step();
    end
    idle(10);

    // Branch mispredict at tag 2.
    do_reset();
    clear_inputs(); set_issue(2'd0, 5'd1, 1'b0, 1'b1); step();
    clear_inputs(); set_issue(2'd0, 5'd2, 1'b0, 1'b1); step();
    clear_inputs(); set_issue(2'd2, 5'd0, 1'b0, 1'b0); step();
    clear_inputs(); set_issue(2'd0, 5'd4, 1'b0, 1'b1); step();
    clear_inputs(); set_issue(2'd0, 5'd5, 1'b0, 1'b1); step();
    clear_inputs(); set_wb(0, 4'd2, 32'h0, 1'b1, 32'h1000); step();
    idle(4);

    // Store paired with a register write, then two stores.
    do_reset();
    clear_inputs(); set_issue(2'd1, 5'd0, 1'b0, 1'b0); step();
    clear_inputs(); set_issue(2'd0, 5'd7, 1'b0, 1'b1); step();
    clear_inputs(); set_wb(1, 4'd0, 32'h55, 1'b0, 32'h0); step();
    idle(3);
    clear_inputs(); set_issue(2'd1, 5'd0, 1'b0, 1'b0); step();
    clear_inputs(); set_issue(2'd1, 5'd0, 1'b0, 1'b0); step();
    clear_inputs(); set_wb(0, 4'd2, 32'h1, 1'b0, 32'h0); set_wb(1, 4'd3, 32'h2, 1'b0, 32'h0);
    step();
    idle(4);

    // Operand bypass from both channels.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      clear_inputs(); set_issue(2'd0, 5'(i + 1), 1'b0, 1'b0); step();
    end
    clear_inputs(); q1_tag = 4'd5; q2_tag = 4'd6; step();
    set_wb(0, 4'd5, 32'hCAFE_0005, 1'b0, 32'h0); set_wb(1, 4'd6, 32'hBEEF_0006, 1'b0, 32'h0);
    step();
    clear_inputs(); q1_tag = 4'd5; q2_tag = 4'd6;
    set_wb(0, 4'd5, 32'h1111, 1'b0, 32'h0); set_wb(1, 4'd5, 32'h2222, 1'b0, 32'h0); step();

    // Reset while a flush is showing, then rdy low over a ready head.
    do_reset();
    clear_inputs(); set_issue(2'd2, 5'd0, 1'b1, 1'b1); step();
    clear_inputs(); step();
    chk("flush_visible", 64'(flush), 64'(1));
    @(negedge clk);
    #1;
    do_reset();
    chk("flush_after_reset", 64'(flush), 64'(0));
    clear_inputs(); set_issue(2'd0, 5'd3, 1'b0, 1'b1); step();
    for (int i = 0; i < 3; i++) begin
      clear_inputs(); rdy = 1'b0; set_issue(2'd0, 5'd4, 1'b0, 1'b1); step();
    end
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if (i % 1000 == 999) do_reset();
      random_inputs();
      step();
    end
    idle(3);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
